// File: rtl/key_cmd_if.sv
// Keypad-side bundle: raw key code and held flag in, decoded command pulses out.
interface key_cmd_if;
    logic [3:0] tecla;
    logic       flag;
    logic       p1_up;
    logic       p1_down;
    logic       p1_fire;
    logic       p2_up;
    logic       p2_down;
    logic       p2_fire;
    logic       key_pulse;
    logic [3:0] key_code;

    modport master (
        output tecla, flag,
        input  p1_up, p1_down, p1_fire, p2_up, p2_down, p2_fire, key_pulse, key_code
    );

    modport slave (
        input  tecla, flag,
        output p1_up, p1_down, p1_fire, p2_up, p2_down, p2_fire, key_pulse, key_code
    );
endinterface

// File: rtl/key_cmd_decoder.sv
// Debounces keypad presses, auto-repeats movement keys and maps key codes to
// single-cycle player command pulses.
module key_cmd_decoder #(
    parameter int DEBOUNCE_CYC  = 250000,
    parameter int REPEAT_DELAY  = 7500000,
    parameter int REPEAT_PERIOD = 2500000,
    parameter int CNT_W         = 24
) (
    input  logic     clk,
    input  logic     nreset,
    key_cmd_if.slave kb
);

    localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] RD_C  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RP_C  = CNT_W'(REPEAT_PERIOD);

    typedef enum logic [2:0] {ARM, IDLE, DEB, HOLD, REPEAT} state_t;

    state_t           state, state_nx;
    logic             flag_m, flag_s;
    logic [3:0]       tecla_m, tecla_s;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic [CNT_W-1:0] rel, rel_nx, rel_inc;
    logic [3:0]       key_code_nx, fire_code;
    logic             fire, repeatable;
    logic [5:0]       cmd_nx;

    // Two-flop synchronizer; nothing downstream looks at the raw inputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            flag_m  <= 1'b0;
            flag_s  <= 1'b0;
            tecla_m <= '0;
            tecla_s <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its source.
            flag_m  <= kb.flag;
            flag_s  <= flag_m;
            tecla_m <= kb.tecla;
            tecla_s <= tecla_m;
        end
    end

    assign cnt_inc    = (cnt == '1) ? cnt : cnt + 1'b1;
    assign rel_inc    = (rel == '1) ? rel : rel + 1'b1;
    assign repeatable = (kb.key_code == 4'h5) || (kb.key_code == 4'h0) ||
                        (kb.key_code == 4'h3) || (kb.key_code == 4'h9);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_nx    = state;
        cnt_nx      = cnt;
        rel_nx      = rel;
        key_code_nx = kb.key_code;
        fire        = 1'b0;
        fire_code   = kb.key_code;
        case (state)
            ARM: begin
                if (flag_s) begin
                    cnt_nx = '0;
                end else if (cnt_inc == DEB_C) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            IDLE: begin
                if (flag_s) begin
                    state_nx = DEB;
                    cnt_nx   = '0;
                end
            end
            DEB: begin
                if (!flag_s) begin
                    state_nx = IDLE;
                end else if (cnt_inc == DEB_C) begin
                    state_nx    = HOLD;
                    cnt_nx      = '0;
                    rel_nx      = '0;
                    key_code_nx = tecla_s;
                    fire        = 1'b1;
                    fire_code   = tecla_s;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            HOLD, REPEAT: begin
                // Repeat timer keeps running through short drops; only a full release stops it.
                cnt_nx = cnt_inc;
                rel_nx = flag_s ? '0 : rel_inc;
                if (!flag_s && (rel_inc == DEB_C)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    rel_nx   = '0;
                end else if (repeatable && (cnt_inc == ((state == HOLD) ? RD_C : RP_C))) begin
                    state_nx = REPEAT;
                    cnt_nx   = '0;
                    fire     = 1'b1;
                end
            end
            default: state_nx = ARM;
        endcase
    end

    always_comb begin
        cmd_nx = '0;
        if (fire) begin
            case (fire_code)
                4'h5:    cmd_nx = 6'b100000;
                4'h0:    cmd_nx = 6'b010000;
                4'hA:    cmd_nx = 6'b001000;
                4'h3:    cmd_nx = 6'b000100;
                4'h9:    cmd_nx = 6'b000010;
                4'hB:    cmd_nx = 6'b000001;
                default: cmd_nx = 6'b000000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= ARM;
            cnt         <= '0;
            rel         <= '0;
            kb.key_code <= '0;
            kb.key_pulse <= 1'b0;
            kb.p1_up    <= 1'b0;
            kb.p1_down  <= 1'b0;
            kb.p1_fire  <= 1'b0;
            kb.p2_up    <= 1'b0;
            kb.p2_down  <= 1'b0;
            kb.p2_fire  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            rel         <= rel_nx;
            kb.key_code <= key_code_nx;
            kb.key_pulse <= fire;
            kb.p1_up    <= cmd_nx[5];
            kb.p1_down  <= cmd_nx[4];
            kb.p1_fire  <= cmd_nx[3];
            kb.p2_up    <= cmd_nx[2];
            kb.p2_down  <= cmd_nx[1];
            kb.p2_fire  <= cmd_nx[0];
        end
    end

endmodule
